// File: rtl/fc_layer_ctrl.sv
// Layer sequencer for a shared binary-weight FC neuron: fetches {bias, weights} per output,
// fires the neuron, streams each result and tracks a running signed argmax.
module fc_layer_ctrl #(
    parameter int NUM_OUT = 10,
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_start,
    input  logic [159:0]   i_in_vec,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_err,
    output logic           o_w_rd,
    output logic [AW-1:0]  o_w_addr,
    input  logic [16:0]    i_w_rdata,
    output logic           o_nrn_start,
    output logic [15:0]    o_nrn_weight,
    output logic           o_nrn_bias,
    output logic [159:0]   o_nrn_in,
    input  logic [14:0]    i_nrn_out,
    input  logic           i_nrn_end,
    output logic           o_res_valid,
    output logic [AW-1:0]  o_res_idx,
    output logic [14:0]    o_res_data,
    output logic [AW-1:0]  o_argmax_idx,
    output logic [14:0]    o_argmax_val
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_OUT - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LOAD, S_FIRE, S_WAIT, S_DONE
    } state_t;

    state_t         r_state, w_next;
    logic [AW-1:0]  r_idx;
    logic [CW-1:0]  r_wcnt;
    logic [159:0]   r_in;
    logic [15:0]    r_weight;
    logic           r_bias;
    logic           r_err;
    logic           r_res_valid;
    logic [AW-1:0]  r_res_idx;
    logic [14:0]    r_res_data;
    logic [AW-1:0]  r_amax_idx;
    logic [14:0]    r_amax_val;
    logic           w_timeout;
    logic           w_amax_upd;

    assign w_timeout  = (r_wcnt == TO_LAST);
    // First result always loads; later ones must be strictly greater so ties keep the lowest index.
    assign w_amax_upd = (r_idx == '0) || ($signed(i_nrn_out) > $signed(r_amax_val));

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_next = S_FETCH;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = S_FIRE;
            S_FIRE:  w_next = S_WAIT;
            S_WAIT: begin
                if (i_nrn_end)      w_next = (r_idx == LAST_IDX) ? S_DONE : S_FETCH;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (r_state != S_IDLE);
        o_w_rd      = (r_state == S_FETCH);
        o_nrn_start = (r_state == S_FIRE);
        o_done      = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_idx       <= '0;
            r_wcnt      <= '0;
            r_in        <= '0;
            r_weight    <= '0;
            r_bias      <= 1'b0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_idx   <= '0;
            r_res_data  <= '0;
            r_amax_idx  <= '0;
            r_amax_val  <= '0;
        end else begin
            r_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_in       <= i_in_vec;
                    r_idx      <= '0;
                    r_err      <= 1'b0;
                    r_amax_idx <= '0;
                    r_amax_val <= '0;
                end
                S_LOAD: begin
                    r_bias   <= i_w_rdata[16];
                    r_weight <= i_w_rdata[15:0];
                end
                S_FIRE: r_wcnt <= '0;
                S_WAIT: begin
                    if (i_nrn_end) begin
                        r_res_valid <= 1'b1;
                        r_res_data  <= i_nrn_out;
                        r_res_idx   <= r_idx;
                        if (w_amax_upd) begin
                            r_amax_idx <= r_idx;
                            r_amax_val <= i_nrn_out;
                        end
                        if (r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_wcnt <= r_wcnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_err        = r_err;
    assign o_w_addr     = r_idx;
    assign o_nrn_weight = r_weight;
    assign o_nrn_bias   = r_bias;
    assign o_nrn_in     = r_in;
    assign o_res_valid  = r_res_valid;
    assign o_res_idx    = r_res_idx;
    assign o_res_data   = r_res_data;
    assign o_argmax_idx = r_amax_idx;
    assign o_argmax_val = r_amax_val;
endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Bench for fc_layer_ctrl: weight memory and binary-weight neuron models, per-scenario tasks,
// expected results computed directly from inputs/weights.
module tb_fc_layer_ctrl;
    localparam int NUM_OUT = 10;
    localparam int AW      = 4;
    localparam int TIMEOUT = 15;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [159:0] in_vec = '0;
    logic         busy, done, err, w_rd, nrn_start, nrn_bias, nrn_end, res_valid;
    logic [AW-1:0] w_addr, res_idx, argmax_idx;
    logic [16:0]  w_rdata = '0;
    logic [15:0]  nrn_weight;
    logic [159:0] nrn_in;
    logic [14:0]  nrn_out, res_data, argmax_val;

    int tests = 0, fails = 0;

    fc_layer_ctrl #(.NUM_OUT(NUM_OUT), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_in_vec(in_vec),
        .o_busy(busy), .o_done(done), .o_err(err), .o_w_rd(w_rd), .o_w_addr(w_addr),
        .i_w_rdata(w_rdata), .o_nrn_start(nrn_start), .o_nrn_weight(nrn_weight),
        .o_nrn_bias(nrn_bias), .o_nrn_in(nrn_in), .i_nrn_out(nrn_out), .i_nrn_end(nrn_end),
        .o_res_valid(res_valid), .o_res_idx(res_idx), .o_res_data(res_data),
        .o_argmax_idx(argmax_idx), .o_argmax_val(argmax_val)
    );

    always #5 clk = ~clk;

    // ---------------- models ----------------
    logic [16:0]  mem [0:15];
    logic [14:0]  force_res [0:NUM_OUT-1];
    bit           force_mode = 0, hang_mode = 0, hold_start = 0;
    logic         inj_end = 1'b0;
    logic         p1 = 1'b0, p2 = 1'b0, m_end = 1'b0;
    logic [14:0]  m_val = '0;
    logic [AW-1:0] m_idx = '0;

    function automatic int nref(input logic [15:0] w, input logic b, input logic [159:0] x);
        int s;
        logic signed [9:0] xi;
        s = b ? 1 : -1;
        for (int i = 0; i < 16; i++) begin
            xi = x[159-10*i -: 10];
            s += w[15-i] ? int'(xi) : -int'(xi);
        end
        return s;
    endfunction

    function automatic int amax(input int v[NUM_OUT]);
        int b = 0;
        for (int i = 1; i < NUM_OUT; i++) if (v[i] > v[b]) b = i;
        return b;
    endfunction

    always @(posedge clk) begin
        if (w_rd) begin
            w_rdata <= mem[w_addr];
            m_idx   <= w_addr;
        end
        p1    <= nrn_start & ~hang_mode;
        p2    <= p1;
        m_end <= p2;
        if (nrn_start) m_val <= force_mode ? force_res[m_idx] : 15'(nref(nrn_weight, nrn_bias, nrn_in));
    end
    assign nrn_out = m_val;
    assign nrn_end = m_end | inj_end;

    // ---------------- run recorder ----------------
    logic        busy_h [0:127];
    logic        err_h  [0:127];
    int          q_addr[$], q_ridx[$];
    logic [14:0] q_rdata[$];
    int          done_cnt, done_cyc;
    int          exp_r [NUM_OUT];

    task automatic run_layer(input int ncyc);
        q_addr.delete(); q_ridx.delete(); q_rdata.delete();
        done_cnt = 0; done_cyc = -1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            busy_h[k] = busy;
            err_h[k]  = err;
            if (w_rd) q_addr.push_back(int'(w_addr));
            if (res_valid) begin
                q_ridx.push_back(int'(res_idx));
                q_rdata.push_back(res_data);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = k;
            end
        end
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        tests++;
        if ({busy, done, err, w_rd, w_addr, nrn_start, nrn_weight, nrn_bias, nrn_in,
             res_valid, res_idx, res_data, argmax_idx, argmax_val} !== '0) begin
            fails++; $display("FAIL reset_init: outputs not all zero, busy=%b err=%b", busy, err);
        end
        @(negedge clk); rst_n = 1'b1;
        // mid-layer async reset
        in_vec = {5{$urandom}};
        force_mode = 0;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat ($urandom_range(8, 40)) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, err, w_rd, w_addr, nrn_start, nrn_weight, nrn_bias, nrn_in,
             res_valid, res_idx, res_data, argmax_idx, argmax_val} !== '0) begin
            fails++; $display("FAIL reset_mid: outputs not all zero, busy=%b argmax_val=%0h", busy, argmax_val);
        end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        // idle with start low, stray nrn_end ignored
        @(negedge clk); inj_end = 1'b1;
        @(negedge clk); inj_end = 1'b0;
        repeat (5) begin
            @(negedge clk);
            tests++;
            if (busy !== 1'b0 || res_valid !== 1'b0 || w_rd !== 1'b0) begin
                fails++; $display("FAIL reset_idle: busy=%b res_valid=%b w_rd=%b want 0", busy, res_valid, w_rd);
            end
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 16; i++) mem[i] = 17'h1FFFF;
        in_vec = {16{10'd1}};
        force_mode = 0;
        run_layer(64);
        tests++;
        if (done_cyc !== 61 || done_cnt !== 1) begin
            fails++; $display("FAIL basic_done: cycle=%0d count=%0d want 61/1", done_cyc, done_cnt);
        end
        tests++;
        if (busy_h[1] !== 1'b1 || busy_h[61] !== 1'b1 || busy_h[62] !== 1'b0) begin
            fails++; $display("FAIL basic_busy: c1=%b c61=%b c62=%b want 1/1/0", busy_h[1], busy_h[61], busy_h[62]);
        end
        tests++;
        if (q_addr.size() != NUM_OUT || q_rdata.size() != NUM_OUT) begin
            fails++; $display("FAIL basic_count: w_rd=%0d res=%0d want %0d", q_addr.size(), q_rdata.size(), NUM_OUT);
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                tests++;
                if (q_addr[i] != i || q_ridx[i] != i || q_rdata[i] !== 15'd17) begin
                    fails++; $display("FAIL basic_res%0d: addr=%0d idx=%0d data=%0d want %0d/%0d/17",
                                      i, q_addr[i], q_ridx[i], q_rdata[i], i, i);
                end
            end
        end
        tests++;
        if (argmax_idx !== 4'd0 || argmax_val !== 15'd17 || err !== 1'b0) begin
            fails++; $display("FAIL basic_argmax: idx=%0d val=%0d err=%b want 0/17/0", argmax_idx, argmax_val, err);
        end
    endtask

    task automatic test_argmax(input int v[NUM_OUT], input string nm);
        int bi;
        for (int i = 0; i < NUM_OUT; i++) force_res[i] = 15'(v[i]);
        force_mode = 1;
        run_layer(66);
        bi = amax(v);
        tests++;
        if (q_rdata.size() != NUM_OUT || done_cyc !== 61) begin
            fails++; $display("FAIL %s_count: res=%0d done=%0d want %0d/61", nm, q_rdata.size(), done_cyc, NUM_OUT);
        end
        tests++;
        if (argmax_idx !== AW'(bi) || argmax_val !== 15'(v[bi])) begin
            fails++; $display("FAIL %s_argmax: idx=%0d val=%h want %0d/%h", nm, argmax_idx, argmax_val, bi, 15'(v[bi]));
        end
        force_mode = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            in_vec = {$urandom, $urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 16; i++) mem[i] = 17'($urandom);
            for (int i = 0; i < NUM_OUT; i++) exp_r[i] = nref(mem[i][15:0], mem[i][16], in_vec);
            run_layer(64);
            tests++;
            if (q_rdata.size() != NUM_OUT || done_cyc !== 61) begin
                fails++; $display("FAIL rand%0d_count: res=%0d done=%0d", n, q_rdata.size(), done_cyc);
            end else begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    tests++;
                    if (q_ridx[i] != i || q_rdata[i] !== 15'(exp_r[i])) begin
                        fails++; $display("FAIL rand%0d_res%0d: idx=%0d data=%h want %0d/%h",
                                          n, i, q_ridx[i], q_rdata[i], i, 15'(exp_r[i]));
                    end
                end
            end
            tests++;
            if (argmax_idx !== AW'(amax(exp_r)) || argmax_val !== 15'(exp_r[amax(exp_r)])) begin
                fails++; $display("FAIL rand%0d_argmax: idx=%0d val=%h want %0d", n, argmax_idx, argmax_val, amax(exp_r));
            end
        end
    endtask

    task automatic test_hold_start();
        hold_start = 1;
        run_layer(63);
        hold_start = 0;
        tests++;
        if (done_cnt !== 1 || done_cyc !== 61 || q_rdata.size() != NUM_OUT) begin
            fails++; $display("FAIL hold_single: done=%0d@%0d res=%0d want 1@61/%0d", done_cnt, done_cyc, q_rdata.size(), NUM_OUT);
        end
        tests++;
        if (busy_h[62] !== 1'b0 || busy_h[63] !== 1'b1 || q_addr.size() != NUM_OUT + 1) begin
            fails++; $display("FAIL hold_restart: c62=%b c63=%b w_rd=%0d want 0/1/%0d",
                              busy_h[62], busy_h[63], q_addr.size(), NUM_OUT + 1);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        hang_mode = 1;
        run_layer(25);
        tests++;
        if (err_h[18] !== 1'b0 || err_h[19] !== 1'b1 || busy_h[18] !== 1'b1 || busy_h[19] !== 1'b0) begin
            fails++; $display("FAIL timeout_err: err c18/c19=%b/%b busy=%b/%b want 0/1 1/0",
                              err_h[18], err_h[19], busy_h[18], busy_h[19]);
        end
        tests++;
        if (done_cnt !== 0 || q_rdata.size() != 0 || err !== 1'b1) begin
            fails++; $display("FAIL timeout_quiet: done=%0d res=%0d err=%b want 0/0/1", done_cnt, q_rdata.size(), err);
        end
        hang_mode = 0;
        run_layer(64);
        tests++;
        if (err_h[1] !== 1'b0 || done_cyc !== 61 || err !== 1'b0) begin
            fails++; $display("FAIL timeout_clear: err=%b done=%0d want 0/61", err_h[1], done_cyc);
        end
    endtask

    initial begin
        int r3[NUM_OUT] = '{-5, 3, 9, -1, 9, 0, 2, 8, 9, -7};
        int r4[NUM_OUT] = '{-17, -16, -15, -14, -13, -12, -1, -10, -9, -8};
        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < NUM_OUT; i++) force_res[i] = '0;
        #3;
        test_reset();
        test_basic();
        test_argmax(r3, "tie");
        repeat (4) @(negedge clk);
        tests++;
        if (argmax_idx !== 4'd2 || argmax_val !== 15'd9 || busy !== 1'b0) begin
            fails++; $display("FAIL tie_hold: idx=%0d val=%0d busy=%b want 2/9/0", argmax_idx, argmax_val, busy);
        end
        test_argmax(r4, "neg");
        test_random();
        test_hold_start();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
